dmem_access_ctrl: RTL and testbench

Sequencing controller between the core's memory stage and the single-port data memory bus. It accepts one load/store request at a time and generates the word-aligned bus address, byte write mask and rotated store data. Misaligned halfword/word accesses are split into two bus beats, and load words are merged before being handed to the load unit. It owns the memory-stage stall while an access is outstanding.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_beat_gen.sv | 43 ++++
 rtl/dmem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DW2 = 2 * DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte enables across two consecutive words; size 11 behaves as a word.
  function automatic logic [7:0] base_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/dmem_beat_gen.sv
// Per-beat address, byte mask and rotated store data for one request.
module dmem_beat_gen
  import dmem_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          split_c,
  output logic          misaligned_c,
  output logic [AW-1:0] addr0_c,
  output logic [AW-1:0] addr1_c,
  output logic [3:0]    mask0_c,
  output logic [3:0]    mask1_c,
  output logic [DW-1:0] wdata0_c,
  output logic [DW-1:0] wdata1_c
);

  logic [1:0]     off;
  logic [7:0]     mask8;
  logic [DW2-1:0] wdata64;

  always_comb begin
    off = addr[1:0];
    case (size)
      SZ_BYTE: misaligned_c = 1'b0;
      SZ_HALF: misaligned_c = (off == 2'd3);
      default: misaligned_c = (off != 2'd0);
    endcase
    split_c  = misaligned_c & SPLIT_MISALIGNED;
    // Second beat wraps past the top of the address space.
    addr0_c  = {addr[AW-1:2], 2'b00};
    addr1_c  = addr0_c + AW'(4);
    mask8    = base_mask(size, off);
    mask0_c  = mask8[3:0];
    mask1_c  = mask8[7:4];
    wdata64  = DW2'(wdata) << {off, 3'b000};
    wdata0_c = wdata64[DW-1:0];
    wdata1_c = wdata64[DW2-1:DW];
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage to data-bus sequencer: one request at a time, misaligned
// accesses split into two word beats, split loads merged for the load unit.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          req_valid_in,
  output logic          req_ready_out,
  input  logic          req_write_in,
  input  logic [1:0]    req_size_in,
  input  logic [AW-1:0] req_addr_in,
  input  logic [DW-1:0] req_wdata_in,
  output logic          dm_req_out,
  output logic          dm_wr_out,
  output logic [AW-1:0] dm_addr_out,
  output logic [3:0]    dm_wmask_out,
  output logic [DW-1:0] dm_wdata_out,
  input  logic          dm_ack_in,
  input  logic [DW-1:0] dm_rdata_in,
  output logic          resp_valid_out,
  output logic [DW-1:0] lu_data_out,
  output logic [1:0]    lu_offset_out,
  output logic          misaligned_exc_out,
  output logic          stall_out
);

  state_t        state;
  logic          lat_write;
  logic [1:0]    lat_size;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] beat0_data;

  logic [1:0]     sel_size_c;
  logic [AW-1:0]  sel_addr_c;
  logic [DW-1:0]  sel_wdata_c;
  logic           split_c, misaligned_c;
  logic [AW-1:0]  addr0_c, addr1_c;
  logic [3:0]     mask0_c, mask1_c;
  logic [DW-1:0]  wdata0_c, wdata1_c;
  logic [DW2-1:0] merged_c;

  // In IDLE the incoming request feeds the generator so beat 0 can be registered on accept.
  always_comb begin
    sel_size_c  = (state == S_IDLE) ? req_size_in  : lat_size;
    sel_addr_c  = (state == S_IDLE) ? req_addr_in  : lat_addr;
    sel_wdata_c = (state == S_IDLE) ? req_wdata_in : lat_wdata;
    merged_c    = {dm_rdata_in, beat0_data} >> {lat_addr[1:0], 3'b000};
  end

  dmem_beat_gen #(
    .SPLIT_MISALIGNED(SPLIT_MISALIGNED)
  ) u_beat_gen (
    .size        (sel_size_c),
    .addr        (sel_addr_c),
    .wdata       (sel_wdata_c),
    .split_c     (split_c),
    .misaligned_c(misaligned_c),
    .addr0_c     (addr0_c),
    .addr1_c     (addr1_c),
    .mask0_c     (mask0_c),
    .mask1_c     (mask1_c),
    .wdata0_c    (wdata0_c),
    .wdata1_c    (wdata1_c)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= S_IDLE;
      lat_write          <= 1'b0;
      lat_size           <= SZ_BYTE;
      lat_addr           <= '0;
      lat_wdata          <= '0;
      beat0_data         <= '0;
      req_ready_out      <= 1'b1;
      stall_out          <= 1'b0;
      dm_req_out         <= 1'b0;
      dm_wr_out          <= 1'b0;
      dm_addr_out        <= '0;
      dm_wmask_out       <= '0;
      dm_wdata_out       <= '0;
      resp_valid_out     <= 1'b0;
      lu_data_out        <= '0;
      lu_offset_out      <= '0;
      misaligned_exc_out <= 1'b0;
    end else begin
      resp_valid_out     <= 1'b0;
      misaligned_exc_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_in) begin
            lat_write     <= req_write_in;
            lat_size      <= req_size_in;
            lat_addr      <= req_addr_in;
            lat_wdata     <= req_wdata_in;
            req_ready_out <= 1'b0;
            stall_out     <= 1'b1;
            if (misaligned_c && !SPLIT_MISALIGNED) begin
              state              <= S_RESP;
              resp_valid_out     <= 1'b1;
              misaligned_exc_out <= 1'b1;
              lu_data_out        <= '0;
              lu_offset_out      <= '0;
            end else begin
              state        <= S_BEAT0;
              dm_req_out   <= 1'b1;
              dm_wr_out    <= req_write_in;
              dm_addr_out  <= addr0_c;
              dm_wmask_out <= req_write_in ? mask0_c : 4'b0000;
              dm_wdata_out <= req_write_in ? wdata0_c : '0;
            end
          end
        end
        S_BEAT0: begin
          if (dm_ack_in) begin
            beat0_data <= dm_rdata_in;
            if (split_c) begin
              state        <= S_BEAT1;
              dm_addr_out  <= addr1_c;
              dm_wmask_out <= lat_write ? mask1_c : 4'b0000;
              dm_wdata_out <= lat_write ? wdata1_c : '0;
            end else begin
              state          <= S_RESP;
              dm_req_out     <= 1'b0;
              dm_wr_out      <= 1'b0;
              dm_addr_out    <= '0;
              dm_wmask_out   <= '0;
              dm_wdata_out   <= '0;
              resp_valid_out <= 1'b1;
              lu_data_out    <= lat_write ? '0 : dm_rdata_in;
              lu_offset_out  <= lat_write ? 2'b00 : lat_addr[1:0];
            end
          end
        end
        S_BEAT1: begin
          if (dm_ack_in) begin
            state          <= S_RESP;
            dm_req_out     <= 1'b0;
            dm_wr_out      <= 1'b0;
            dm_addr_out    <= '0;
            dm_wmask_out   <= '0;
            dm_wdata_out   <= '0;
            resp_valid_out <= 1'b1;
            lu_data_out    <= lat_write ? '0 : merged_c[DW-1:0];
            lu_offset_out  <= 2'b00;
          end
        end
        default: begin
          state         <= S_IDLE;
          req_ready_out <= 1'b1;
          stall_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: split and non-split instances.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        rv_ns = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;

  logic        req_ready, dm_req, dm_wr, resp_valid, exc, stall;
  logic [31:0] dm_addr, dm_wdata, lu_data;
  logic [3:0]  dm_wmask;
  logic [1:0]  lu_offset;

  logic        ns_req_ready, ns_dm_req, ns_dm_wr, ns_resp_valid, ns_exc, ns_stall;
  logic [31:0] ns_dm_addr, ns_dm_wdata, ns_lu_data;
  logic [3:0]  ns_dm_wmask;
  logic [1:0]  ns_lu_offset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_write_in(req_write), .req_size_in(req_size), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .dm_req_out(dm_req), .dm_wr_out(dm_wr),
    .dm_addr_out(dm_addr), .dm_wmask_out(dm_wmask), .dm_wdata_out(dm_wdata),
    .dm_ack_in(dm_ack), .dm_rdata_in(dm_rdata), .resp_valid_out(resp_valid),
    .lu_data_out(lu_data), .lu_offset_out(lu_offset),
    .misaligned_exc_out(exc), .stall_out(stall)
  );

  dmem_access_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk_in(clk), .rst_in(rst), .req_valid_in(rv_ns), .req_ready_out(ns_req_ready),
    .req_write_in(req_write), .req_size_in(req_size), .req_addr_in(req_addr),
    .req_wdata_in(req_wdata), .dm_req_out(ns_dm_req), .dm_wr_out(ns_dm_wr),
    .dm_addr_out(ns_dm_addr), .dm_wmask_out(ns_dm_wmask), .dm_wdata_out(ns_dm_wdata),
    .dm_ack_in(dm_ack), .dm_rdata_in(dm_rdata), .resp_valid_out(ns_resp_valid),
    .lu_data_out(ns_lu_data), .lu_offset_out(ns_lu_offset),
    .misaligned_exc_out(ns_exc), .stall_out(ns_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wmask", 32'(dm_wmask), 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_lu_data", lu_data, 32'h0);
    chk("rst_lu_off", 32'(lu_offset), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned word load at 0x100, zero-wait ack
    issue(1'b0, 2'b10, 32'h100, 32'h0);
    chk("t1_dm_req", 32'(dm_req), 32'd1);
    chk("t1_dm_wr", 32'(dm_wr), 32'd0);
    chk("t1_addr", dm_addr, 32'h100);
    chk("t1_mask", 32'(dm_wmask), 32'h0);
    chk("t1_stall", 32'(stall), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'hAABBCCDD;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t1_resp", 32'(resp_valid), 32'd1);
    chk("t1_lu_data", lu_data, 32'hAABBCCDD);
    chk("t1_lu_off", 32'(lu_offset), 32'd0);
    chk("t1_dm_req_off", 32'(dm_req), 32'd0);
    @(negedge clk);
    chk("t1_resp_pulse", 32'(resp_valid), 32'd0);
    chk("t1_ready_back", 32'(req_ready), 32'd1);
    chk("t1_stall_back", 32'(stall), 32'd0);

    // Byte store 0x5A at 0x203
    issue(1'b1, 2'b00, 32'h203, 32'h5A);
    chk("t2_dm_wr", 32'(dm_wr), 32'd1);
    chk("t2_addr", dm_addr, 32'h200);
    chk("t2_mask", 32'(dm_wmask), 32'h8);
    chk("t2_wdata", dm_wdata, 32'h5A000000);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t2_resp", 32'(resp_valid), 32'd1);
    chk("t2_lu_data", lu_data, 32'h0);
    @(negedge clk);

    // Misaligned word load at 0x102: two beats, merged
    issue(1'b0, 2'b10, 32'h102, 32'h0);
    chk("t3_addr0", dm_addr, 32'h100);
    chk("t3_mask0", 32'(dm_wmask), 32'h0);
    dm_ack = 1'b1; dm_rdata = 32'h44332211;
    @(negedge clk);
    chk("t3_dm_req1", 32'(dm_req), 32'd1);
    chk("t3_addr1", dm_addr, 32'h104);
    chk("t3_no_resp", 32'(resp_valid), 32'd0);
    dm_rdata = 32'h88776655;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t3_resp", 32'(resp_valid), 32'd1);
    chk("t3_lu_data", lu_data, 32'h66554433);
    chk("t3_lu_off", 32'(lu_offset), 32'd0);
    @(negedge clk);

    // Half store 0xBEEF at 0xFFFFFFFF, second beat wraps to 0
    issue(1'b1, 2'b01, 32'hFFFFFFFF, 32'h0000BEEF);
    chk("t4_addr0", dm_addr, 32'hFFFFFFFC);
    chk("t4_mask0", 32'(dm_wmask), 32'h8);
    chk("t4_wdata0", dm_wdata, 32'hEF000000);
    dm_ack = 1'b1;
    @(negedge clk);
    chk("t4_addr1", dm_addr, 32'h0);
    chk("t4_mask1", 32'(dm_wmask), 32'h1);
    chk("t4_wdata1", dm_wdata, 32'h000000BE);
    chk("t4_wr1", 32'(dm_wr), 32'd1);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t4_resp", 32'(resp_valid), 32'd1);
    @(negedge clk);

    // Load at 0x100 with three wait cycles
    issue(1'b0, 2'b10, 32'h100, 32'h0);
    chk("t5_addr", dm_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_req", 32'(dm_req), 32'd1);
      chk("t5_hold_addr", dm_addr, 32'h100);
      chk("t5_hold_mask", 32'(dm_wmask), 32'h0);
      chk("t5_stall", 32'(stall), 32'd1);
      chk("t5_no_resp", 32'(resp_valid), 32'd0);
    end
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t5_resp", 32'(resp_valid), 32'd1);
    chk("t5_lu_data", lu_data, 32'h12345678);
    @(negedge clk);

    // Aligned byte load at 0x103 reports its offset
    issue(1'b0, 2'b00, 32'h103, 32'h0);
    chk("t6_addr", dm_addr, 32'h100);
    dm_ack = 1'b1; dm_rdata = 32'h11223344;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t6_resp", 32'(resp_valid), 32'd1);
    chk("t6_lu_data", lu_data, 32'h11223344);
    chk("t6_lu_off", 32'(lu_offset), 32'd3);
    @(negedge clk);

    // Non-split instance rejects misaligned word load at 0x101
    rv_ns = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h101;
    @(negedge clk);
    rv_ns = 1'b0;
    chk("t7_exc", 32'(ns_exc), 32'd1);
    chk("t7_resp", 32'(ns_resp_valid), 32'd1);
    chk("t7_no_req", 32'(ns_dm_req), 32'd0);
    @(negedge clk);
    chk("t7_exc_pulse", 32'(ns_exc), 32'd0);
    chk("t7_no_req2", 32'(ns_dm_req), 32'd0);
    chk("t7_ready", 32'(ns_req_ready), 32'd1);

    // Reset while waiting in the second beat; late ack ignored
    issue(1'b0, 2'b10, 32'h102, 32'h0);
    dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t8_beat1_addr", dm_addr, 32'h104);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t8_req_drop", 32'(dm_req), 32'd0);
    chk("t8_ready", 32'(req_ready), 32'd1);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("t8_no_resp", 32'(resp_valid), 32'd0);
    chk("t8_still_idle", 32'(dm_req), 32'd0);
    @(negedge clk);
    chk("t8_no_resp2", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
